// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction into a single registered entry
// holding ALU operands and writeback info. Optional macro: ALU_ISSUE_FORWARD_EN.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic        mem_wen,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_A,
    output logic [31:0] out_B,
    output logic [2:0]  out_ALUop,
    output logic        out_wen,
    output logic [4:0]  out_waddr,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] sext;
    logic [31:0] zext;

    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign rd     = in_inst[15:11];
    assign funct  = in_inst[5:0];
    assign imm    = in_inst[15:0];
    assign sext   = {{16{imm[15]}}, imm};
    assign zext   = {16'h0, imm};

    logic [31:0] rs_v;
    logic [31:0] rt_v;
    logic        use_rs;
    logic        use_rt;
    logic        wbmem_haz;
    logic        unused_ok;

`ifdef ALU_ISSUE_FORWARD_EN
    // MEM result is younger than WB, so it wins when both match
    assign rs_v = (rs != 5'd0 && mem_wen && mem_waddr == rs) ? mem_wdata :
                  (rs != 5'd0 && wb_wen && wb_waddr == rs)   ? wb_wdata  :
                  in_rs_val;
    assign rt_v = (rt != 5'd0 && mem_wen && mem_waddr == rt) ? mem_wdata :
                  (rt != 5'd0 && wb_wen && wb_waddr == rt)   ? wb_wdata  :
                  in_rt_val;
    assign wbmem_haz = 1'b0;
    assign unused_ok = ^in_inst[10:6];
`else
    assign rs_v = in_rs_val;
    assign rt_v = in_rt_val;
    assign wbmem_haz =
        (use_rs && rs != 5'd0 &&
         ((mem_wen && mem_waddr == rs) || (wb_wen && wb_waddr == rs))) ||
        (use_rt && rt != 5'd0 &&
         ((mem_wen && mem_waddr == rt) || (wb_wen && wb_waddr == rt)));
    assign unused_ok = ^{in_inst[10:6], mem_wdata, wb_wdata};
`endif

    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [2:0]  d_op;
    logic [4:0]  d_waddr;
    logic        d_ill;

    // Decode the incoming instruction into operands, opcode and destination
    always_comb begin
        d_a     = rs_v;
        d_b     = sext;
        d_op    = OP_ADD;
        d_waddr = rt;
        d_ill   = 1'b0;
        use_rs  = 1'b1;
        use_rt  = 1'b0;
        unique case (opcode)
            6'b000000: begin
                d_b     = rt_v;
                d_waddr = rd;
                use_rt  = 1'b1;
                unique case (funct)
                    6'b100000, 6'b100001: d_op = OP_ADD;
                    6'b100010, 6'b100011: d_op = OP_SUB;
                    6'b100100: d_op = OP_AND;
                    6'b100101: d_op = OP_OR;
                    6'b100110: d_op = OP_XOR;
                    6'b100111: d_op = OP_NOR;
                    6'b101010: d_op = OP_SLT;
                    6'b101011: d_op = OP_SLTU;
                    default:   d_ill = 1'b1;
                endcase
            end
            6'b001001: d_op = OP_ADD;
            6'b001010: d_op = OP_SLT;
            6'b001011: d_op = OP_SLTU;
            6'b001100: begin d_op = OP_AND; d_b = zext; end
            6'b001101: begin d_op = OP_OR;  d_b = zext; end
            6'b001110: begin d_op = OP_XOR; d_b = zext; end
            6'b001111: begin
                d_a    = 32'h0;
                d_b    = {imm, 16'h0};
                use_rs = 1'b0;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_a     = 32'h0;
            d_b     = 32'h0;
            d_op    = OP_ADD;
            d_waddr = 5'd0;
            use_rs  = 1'b0;
            use_rt  = 1'b0;
        end
    end

    logic ex_haz;
    logic stall;
    logic capture;

    assign ex_haz = out_valid && out_wen &&
        ((use_rs && rs != 5'd0 && out_waddr == rs) ||
         (use_rt && rt != 5'd0 && out_waddr == rt));
    assign stall    = ex_haz || (in_valid && wbmem_haz);
    assign in_ready = !flush && !stall && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    // Single issue entry: flush beats capture, capture beats drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_A       <= 32'h0;
            out_B       <= 32'h0;
            out_ALUop   <= 3'b000;
            out_wen     <= 1'b0;
            out_waddr   <= 5'd0;
            out_pc      <= 32'h0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_A       <= d_a;
            out_B       <= d_b;
            out_ALUop   <= d_op;
            out_wen     <= !d_ill && (d_waddr != 5'd0);
            out_waddr   <= d_waddr;
            out_pc      <= in_pc;
            out_illegal <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: the driver queues hand-computed entries,
// the monitor checks each entry the ALU side accepts.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst, in_pc, in_rs_val, in_rt_val;
    logic        mem_wen, wb_wen;
    logic [4:0]  mem_waddr, wb_waddr;
    logic [31:0] mem_wdata, wb_wdata;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_A, out_B, out_pc;
    logic [2:0]  out_ALUop;
    logic        out_wen, out_illegal;
    logic [4:0]  out_waddr;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .out_ALUop(out_ALUop),
        .out_wen(out_wen), .out_waddr(out_waddr),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic wen,
                                input logic [4:0] wa, input logic [31:0] pc,
                                input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.wen = wen;
        e.waddr = wa; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Present one instruction, wait for acceptance, queue its expectation
    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rsv, input logic [31:0] rtv,
                        input exp_t e, input logic push);
        int cnt = 0;
        in_inst = inst; in_pc = pc; in_rs_val = rsv; in_rt_val = rtv;
        in_valid = 1'b1;
        #1;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: pc %h in_ready %b expected 1", pc, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) q.push_back(e);
            #1 in_valid = 1'b0;
        end
    endtask

    // Monitor: every accepted output entry must match the queue head
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_entry: pc %h with empty queue", out_pc);
            end else begin
                e = q.pop_front();
                if ({out_A, out_B, out_ALUop, out_wen, out_waddr, out_pc, out_illegal} !== e) begin
                    n_err++;
                    $display("FAIL entry_pc%h: got A=%h B=%h op=%b wen=%b wa=%0d pc=%h ill=%b expected A=%h B=%h op=%b wen=%b wa=%0d pc=%h ill=%b",
                             e.pc, out_A, out_B, out_ALUop, out_wen, out_waddr, out_pc, out_illegal,
                             e.a, e.b, e.op, e.wen, e.waddr, e.pc, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_inst = 0; in_pc = 0; in_rs_val = 0; in_rt_val = 0;
        mem_wen = 0; mem_waddr = 0; mem_wdata = 0;
        wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
        #2;
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_A", out_A, 0);
        chk("rst_B", out_B, 0);
        chk("rst_misc", {out_ALUop, out_wen, out_waddr, out_illegal}, 0);
        chk("rst_pc", out_pc, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // add $2,$4,$5 -> 1-cycle latency
        send(32'h00851020, 32'h100, 3, 4, mk(3, 4, 3'b010, 1, 2, 32'h100, 0), 1);
        @(negedge clk);
        chk("latency_valid", {31'h0, out_valid}, 1);
        // ori $3,$0,0x8000 and slti $3,$1,0x8000
        send(32'h34038000, 32'h104, 0, 0, mk(0, 32'h00008000, 3'b001, 1, 3, 32'h104, 0), 1);
        send(32'h28238000, 32'h108, 7, 0, mk(7, 32'hFFFF8000, 3'b111, 1, 3, 32'h108, 0), 1);
        // lui $6,0x1234
        send(32'h3C061234, 32'h10C, 32'hDEAD, 0, mk(0, 32'h12340000, 3'b010, 1, 6, 32'h10C, 0), 1);
        // sub $7,$8,$9
        send(32'h01093822, 32'h110, 50, 8, mk(50, 8, 3'b110, 1, 7, 32'h110, 0), 1);
        // andi $10,$11,0xF0F0
        send(32'h316AF0F0, 32'h114, 32'hFFFF1234, 0, mk(32'hFFFF1234, 32'h0000F0F0, 3'b000, 1, 10, 32'h114, 0), 1);
        // add $0,$4,$5 -> no write
        send(32'h00850020, 32'h118, 9, 10, mk(9, 10, 3'b010, 0, 0, 32'h118, 0), 1);
        // illegal
        send(32'hFC000000, 32'h11C, 5, 6, mk(0, 0, 3'b010, 0, 0, 32'h11C, 1), 1);
        @(negedge clk);
        chk("illegal_flags", {30'h0, out_illegal, out_wen}, 32'h2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Backpressure: xor held, nor waits, then replaces it without bubble
        out_ready = 1'b0;
        send(32'h01AE6026, 32'h200, 32'hA5A5A5A5, 32'h0F0F0F0F,
             mk(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b100, 1, 12, 32'h200, 0), 1);
        in_inst = 32'h02117827; in_pc = 32'h204;
        in_rs_val = 32'h1; in_rt_val = 32'h2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", {31'h0, in_ready}, 0);
            chk("bp_hold_A", out_A, 32'hA5A5A5A5);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h02117827, 32'h204, 1, 2, mk(1, 2, 3'b101, 1, 15, 32'h204, 0), 1);
        @(negedge clk);
        chk("nobubble_valid", {31'h0, out_valid}, 1);
        chk("nobubble_pc", out_pc, 32'h204);
        repeat (2) @(posedge clk); #1;

        // MEM/WB writeback sources on $4
        mem_wen = 1; mem_waddr = 4; mem_wdata = 32'h11;
        wb_wen = 1; wb_waddr = 4; wb_wdata = 32'h22;
`ifdef ALU_ISSUE_FORWARD_EN
        send(32'h00851020, 32'h300, 3, 4, mk(32'h11, 4, 3'b010, 1, 2, 32'h300, 0), 1);
        mem_wen = 0; wb_wen = 0;
`else
        in_inst = 32'h00851020; in_pc = 32'h300;
        in_rs_val = 3; in_rt_val = 4; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nofwd_stall", {31'h0, in_ready}, 0);
        end
        @(posedge clk); #1;
        mem_wen = 0;
        @(negedge clk);
        chk("nofwd_wb_stall", {31'h0, in_ready}, 0);
        @(posedge clk); #1;
        wb_wen = 0;
        send(32'h00851020, 32'h300, 3, 4, mk(3, 4, 3'b010, 1, 2, 32'h300, 0), 1);
`endif
        repeat (2) @(posedge clk); #1;

        // EX hazard: held add writes $2, incoming sub reads $2
        out_ready = 1'b0;
        send(32'h00851020, 32'h400, 1, 2, mk(1, 2, 3'b010, 1, 2, 32'h400, 0), 1);
        in_inst = 32'h00493822; in_pc = 32'h404;
        in_rs_val = 32'h50; in_rt_val = 32'h60; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("haz_hold", {31'h0, in_ready}, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("haz_drain_cycle", {31'h0, in_ready}, 0);
        @(negedge clk);
        chk("haz_release", {31'h0, in_ready}, 1);
        send(32'h00493822, 32'h404, 32'h50, 32'h60, mk(32'h50, 32'h60, 3'b110, 1, 7, 32'h404, 0), 1);
        repeat (2) @(posedge clk); #1;

        // Flush while a new instruction is offered
        out_ready = 1'b0;
        send(32'h02B6A025, 32'h500, 1, 2, mk(0, 0, 0, 0, 0, 0, 0), 0);
        in_inst = 32'h01093822; in_pc = 32'h504; in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", {31'h0, in_ready}, 0);
        @(negedge clk);
        chk("flush_valid", {31'h0, out_valid}, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset pulse while stalled behind a held entry
        send(32'h00851020, 32'h600, 1, 2, mk(0, 0, 0, 0, 0, 0, 0), 0);
        in_inst = 32'h00493822; in_pc = 32'h604; in_valid = 1'b1;
        @(negedge clk);
        chk("rst_stall_ready", {31'h0, in_ready}, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_immediate_valid", {31'h0, out_valid}, 0);
        chk("rst_immediate_pc", out_pc, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_dropped", {31'h0, out_valid}, 0);

        repeat (3) @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
